// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The master side drives the ID/EX observations; the slave side is the controller.
interface pipe_hazard_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rs;
   logic        id_uses_rt;
   logic        ex_is_load;
   logic [4:0]  ex_rd;
   logic        id_branch_taken;
   logic        id_mdu_start;
   logic        id_mdu_is_div;
   logic        id_reads_hilo;
   logic        pc_stall;
   logic        if_id_stall;
   logic        if_id_flush;
   logic        id_ex_bubble;
   logic        mdu_busy;
   logic        mdu_done;
   logic [15:0] stall_count;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_is_load, ex_rd,
             id_branch_taken, id_mdu_start, id_mdu_is_div, id_reads_hilo,
      input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
             mdu_busy, mdu_done, stall_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_is_load, ex_rd,
             id_branch_taken, id_mdu_start, id_mdu_is_div, id_reads_hilo,
      output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
             mdu_busy, mdu_done, stall_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: load-use and MDU stalls,
// branch flush, MDU occupancy countdown and a saturating stall-cycle counter.
//
//   state  | meaning
//   S_IDLE | MDU free; a non-stalled mult/div loads the countdown
//   S_BUSY | MDU occupied; countdown runs, done pulses when it reaches 1
module pipe_hazard_ctrl #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input logic         clk,
   input logic         rst,
   pipe_hazard_if.slave hz
);

   typedef enum logic {S_IDLE, S_BUSY} mdu_state_t;

   mdu_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [15:0]      r_stall_count;

   logic             w_lu;
   logic             w_mh;
   logic             w_stall;
   logic [CNT_W-1:0] w_len;

   always_comb begin
      w_lu = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
             ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
              (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));
      w_mh    = r_busy && (hz.id_reads_hilo || hz.id_mdu_start);
      w_stall = w_lu || w_mh;
      w_len   = hz.id_mdu_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
   end

   assign hz.pc_stall     = w_stall;
   assign hz.if_id_stall  = w_stall;
   assign hz.id_ex_bubble = w_stall;
   // A branch resolved on stale operands is re-evaluated once the stall clears.
   assign hz.if_id_flush  = hz.id_branch_taken && !w_stall;
   assign hz.mdu_busy     = r_busy;
   assign hz.mdu_done     = r_done;
   assign hz.stall_count  = r_stall_count;

   // busy/done are registered alongside the state; done is pre-decoded one
   // cycle ahead so it coincides with cnt==1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (hz.id_mdu_start && !w_stall) begin
                  r_state <= S_BUSY;
                  r_cnt   <= w_len;
                  r_busy  <= 1'b1;
                  r_done  <= (w_len == CNT_W'(1));
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end else begin
                  r_done  <= (r_cnt == CNT_W'(2));
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_count <= 16'd0;
      else if (w_stall && (r_stall_count != 16'hFFFF))
         r_stall_count <= r_stall_count + 16'd1;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with default parameters.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   pipe_hazard_if hz ();

   pipe_hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hz.id_rs = 5'd0; hz.id_rt = 5'd0;
      hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
      hz.ex_is_load = 1'b0; hz.ex_rd = 5'd0;
      hz.id_branch_taken = 1'b0;
      hz.id_mdu_start = 1'b0; hz.id_mdu_is_div = 1'b0;
      hz.id_reads_hilo = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] rd);
      hz.ex_is_load = 1'b1; hz.ex_rd = rd;
      hz.id_rs = rd; hz.id_uses_rs = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      logic [6:0] v;
      v = {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_bubble,
           hz.mdu_busy, hz.mdu_done, (hz.stall_count != 16'd0)};
      chk(tag, {25'd0, v}, 32'd0);
   endtask

   initial begin
      int n_stall;
      int n_busy;
      int n_done;
      int guard;

      idle_inputs();
      tick(); tick();
      rst = 1'b0;
      #1;
      chk_all_zero("reset_idle");

      // load-use, then no hazard on $zero
      set_lu(5'd8);
      #1;
      chk("lu_stall", {29'd0, hz.pc_stall, hz.if_id_stall, hz.id_ex_bubble}, 32'h7);
      tick();
      hz.ex_is_load = 1'b0;
      #1;
      chk("lu_one_cycle", {31'd0, hz.pc_stall}, 32'd0);
      chk("lu_count", {16'd0, hz.stall_count}, 32'd1);
      set_lu(5'd0);
      #1;
      chk("lu_r0_nostall", {31'd0, hz.pc_stall}, 32'd0);
      tick();
      chk("lu_r0_count", {16'd0, hz.stall_count}, 32'd1);
      idle_inputs();

      // branch during load-use: flush deferred one cycle
      set_lu(5'd9);
      hz.id_uses_rs = 1'b0; hz.id_rt = 5'd9; hz.id_uses_rt = 1'b1;
      hz.id_branch_taken = 1'b1;
      #1;
      chk("br_lu_flush", {30'd0, hz.if_id_flush, hz.if_id_stall}, 32'b01);
      tick();
      hz.ex_is_load = 1'b0;
      #1;
      chk("br_after_flush", {30'd0, hz.if_id_flush, hz.if_id_stall}, 32'b10);
      chk("br_count", {16'd0, hz.stall_count}, 32'd2);
      tick();
      idle_inputs();

      // multiply, independent instr, then mflo
      hz.id_mdu_start = 1'b1;
      #1;
      chk("mult_issue", {30'd0, hz.pc_stall, hz.mdu_busy}, 32'd0);
      tick();
      hz.id_mdu_start = 1'b0;
      #1;
      chk("mult_b1", {29'd0, hz.mdu_busy, hz.mdu_done, hz.pc_stall}, 32'b100);
      tick();
      hz.id_reads_hilo = 1'b1;
      #1;
      chk("mult_b2", {29'd0, hz.mdu_busy, hz.mdu_done, hz.pc_stall}, 32'b101);
      tick();
      chk("mult_b3", {29'd0, hz.mdu_busy, hz.mdu_done, hz.pc_stall}, 32'b101);
      tick();
      chk("mult_b4", {29'd0, hz.mdu_busy, hz.mdu_done, hz.pc_stall}, 32'b111);
      tick();
      chk("mflo_go", {29'd0, hz.mdu_busy, hz.mdu_done, hz.pc_stall}, 32'b000);
      chk("mult_count", {16'd0, hz.stall_count}, 32'd5);
      tick();
      idle_inputs();

      // back-to-back divides
      hz.id_mdu_start = 1'b1; hz.id_mdu_is_div = 1'b1;
      #1;
      chk("div1_issue", {31'd0, hz.pc_stall}, 32'd0);
      tick();
      hz.id_mdu_start = 1'b0;
      #1;
      chk("div1_b1", {30'd0, hz.mdu_busy, hz.pc_stall}, 32'b10);
      tick();
      hz.id_mdu_start = 1'b1;
      #1;
      n_stall = 0; n_done = 0; guard = 0;
      while (hz.mdu_busy && guard < 40) begin
         if (hz.pc_stall) n_stall++;
         if (hz.mdu_done) n_done++;
         tick();
         guard++;
      end
      chk("div1_end", {31'd0, hz.mdu_busy}, 32'd0);
      chk("div1_stalls", n_stall, 32'd31);
      chk("div1_done", n_done, 32'd1);
      chk("div2_issue", {31'd0, hz.pc_stall}, 32'd0);
      tick();
      hz.id_mdu_start = 1'b0;
      #1;
      n_busy = 0; n_done = 0; guard = 0;
      while (hz.mdu_busy && guard < 40) begin
         n_busy++;
         if (hz.mdu_done) n_done++;
         tick();
         guard++;
      end
      chk("div2_busy", n_busy, 32'd32);
      chk("div2_done", n_done, 32'd1);
      chk("div_count", {16'd0, hz.stall_count}, 32'd36);
      idle_inputs();

      // reset mid-divide at cnt=17
      hz.id_mdu_start = 1'b1; hz.id_mdu_is_div = 1'b1;
      tick();
      idle_inputs();
      hz.id_reads_hilo = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      chk("rst_pre_busy", {30'd0, hz.mdu_busy, hz.mdu_done}, 32'b10);
      chk("rst_pre_count", {16'd0, hz.stall_count}, 32'd51);
      idle_inputs();
      rst = 1'b1;
      #1;
      chk_all_zero("rst_mid_div");
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (hz.mdu_done || hz.mdu_busy) n_done++;
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (hz.mdu_done || hz.mdu_busy) n_done++;
      end
      chk("rst_no_done", n_done, 32'd0);
      chk_all_zero("rst_after");

      // saturation
      set_lu(5'd3);
      for (int i = 0; i < 65534; i++) tick();
      chk("sat_fffe", {16'd0, hz.stall_count}, 32'hFFFE);
      tick();
      chk("sat_ffff", {16'd0, hz.stall_count}, 32'hFFFF);
      for (int i = 0; i < 70000 - 65535; i++) tick();
      chk("sat_hold", {16'd0, hz.stall_count}, 32'hFFFF);
      idle_inputs();
      tick();
      chk("sat_idle", {15'd0, hz.pc_stall, hz.stall_count}, 32'h0FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
